if_id_stage: RTL and testbench

//   Front-end pipeline stage that consumes the hazard unit's stall/idflush and the ID-stage

---
 rtl/if_id_stage.sv | 111 +++++++++++
 tb/tb_if_id_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID front-end stage: PC register, IF/ID pipeline register and the ID/EX control word.
// Applies stall, redirect or normal advance each edge and keeps saturating event counters.
module if_id_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       CTRL_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               idflush,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [CTRL_W-1:0]  id_ctrl,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc4,
  output logic               if_id_valid,
  output logic [CTRL_W-1:0]  idex_ctrl,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   redirect_cnt
);

  typedef enum logic [1:0] {
    ACT_NORMAL,
    ACT_REDIRECT,
    ACT_STALL
  } action_e;

  action_e            action;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_plus4;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [CTRL_W-1:0]  idex_q, idex_d;
  logic [CNT_W-1:0]   bubble_q, bubble_d;
  logic [CNT_W-1:0]   redirect_q, redirect_d;
  logic               nop_load;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign nop_load = stall | idflush;

  always_comb begin
    if (stall)             action = ACT_STALL;
    else if (branch_taken) action = ACT_REDIRECT;
    else                   action = ACT_NORMAL;
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    idex_d     = nop_load ? '0 : id_ctrl;
    bubble_d   = bubble_q;
    redirect_d = redirect_q;
    case (action)
      ACT_NORMAL: begin
        pc_d    = pc_plus4;
        instr_d = imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
      ACT_REDIRECT: begin
        // Squash the wrong-path fetch already sitting in IF/ID
        pc_d    = {branch_target[ADDR_W-1:2], 2'b00};
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        if (redirect_q != '1) redirect_d = redirect_q + CNT_W'(1);
      end
      default: begin
      end
    endcase
    if (nop_load && bubble_q != '1) bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      idex_q     <= '0;
      bubble_q   <= '0;
      redirect_q <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      idex_q     <= idex_d;
      bubble_q   <= bubble_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc           = pc_q;
  assign imem_addr    = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign idex_ctrl    = idex_q;
  assign bubble_cnt   = bubble_q;
  assign redirect_cnt = redirect_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, corner sequences and
// randomized traffic checked against a behavioural model (two instances: CNT_W=16 and CNT_W=2).
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, idflush, branch_taken;
  logic [31:0] branch_target;
  logic [7:0]  id_ctrl;

  logic [31:0] imem_addr, imem_rdata, pc, if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [7:0]  idex_ctrl;
  logic [15:0] bubble_cnt, redirect_cnt;

  logic [31:0] imem_addr2, imem_rdata2, pc2, if_id_instr2, if_id_pc42;
  logic        if_id_valid2;
  logic [7:0]  idex_ctrl2;
  logic [1:0]  bubble_cnt2, redirect_cnt2;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h1111_0000 + a;
  endfunction

  assign imem_rdata  = imem(imem_addr);
  assign imem_rdata2 = imem(imem_addr2);

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .idflush(idflush), .branch_taken(branch_taken),
    .branch_target(branch_target), .id_ctrl(id_ctrl), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .idex_ctrl(idex_ctrl), .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
  );

  if_id_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .stall(stall), .idflush(idflush), .branch_taken(branch_taken),
    .branch_target(branch_target), .id_ctrl(id_ctrl), .pc(pc2),
    .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42), .if_id_valid(if_id_valid2),
    .idex_ctrl(idex_ctrl2), .bubble_cnt(bubble_cnt2), .redirect_cnt(redirect_cnt2)
  );

  // Reference model: architectural view of the stage, counters unbounded
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [7:0]  m_idex;
  int unsigned m_bub, m_red;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_idex = '0;
    m_bub = 0; m_red = 0;
  endtask

  task automatic model_step();
    if (stall) begin
      m_idex = '0;
      m_bub++;
    end else begin
      m_idex = idflush ? 8'h00 : id_ctrl;
      if (idflush) m_bub++;
      if (branch_taken) begin
        m_pc = branch_target & ~32'd3;
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
        m_red++;
      end else begin
        m_instr = imem(m_pc);
        m_pc = m_pc + 32'd4;
        m_pc4 = m_pc;
        m_valid = 1'b1;
      end
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid,
                             input logic [7:0] e_idex, input int unsigned e_bub,
                             input int unsigned e_red, input string tag);
    chk({tag, ".pc"},        pc,                    e_pc);
    chk({tag, ".imem_addr"}, imem_addr,             e_pc);
    chk({tag, ".instr"},     if_id_instr,           e_instr);
    chk({tag, ".pc4"},       if_id_pc4,             e_pc4);
    chk({tag, ".valid"},     {31'd0, if_id_valid},  {31'd0, e_valid});
    chk({tag, ".idex"},      {24'd0, idex_ctrl},    {24'd0, e_idex});
    chk({tag, ".bubble"},    {16'd0, bubble_cnt},   sat(e_bub, 65535));
    chk({tag, ".redirect"},  {16'd0, redirect_cnt}, sat(e_red, 65535));
    chk({tag, ".pc_w2"},     pc2,                   e_pc);
    chk({tag, ".instr_w2"},  if_id_instr2,          e_instr);
    chk({tag, ".valid_w2"},  {31'd0, if_id_valid2}, {31'd0, e_valid});
    chk({tag, ".idex_w2"},   {24'd0, idex_ctrl2},   {24'd0, e_idex});
    chk({tag, ".bubble_w2"}, {30'd0, bubble_cnt2},  sat(e_bub, 3));
    chk({tag, ".redir_w2"},  {30'd0, redirect_cnt2}, sat(e_red, 3));
  endtask

  task automatic compare_model(input string tag);
    compare_all(m_pc, m_instr, m_pc4, m_valid, m_idex, m_bub, m_red, tag);
  endtask

  task automatic drive(input logic s, input logic f, input logic b,
                       input logic [31:0] t, input logic [7:0] c);
    stall = s; idflush = f; branch_taken = b; branch_target = t; id_ctrl = c;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all(32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 0, 0, "reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        s, f, b;
    logic [31:0] tgt;
    logic [7:0]  ctrl;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid;
    logic [7:0]  e_idex;
    int unsigned e_bub, e_red;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic b,
                              input logic [31:0] tgt, input logic [7:0] ctrl,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_valid,
                              input logic [7:0] e_idex, input int unsigned e_bub,
                              input int unsigned e_red);
    vec_t v;
    v.s = s; v.f = f; v.b = b; v.tgt = tgt; v.ctrl = ctrl;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    v.e_idex = e_idex; v.e_bub = e_bub; v.e_red = e_red;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    //            s     f     b     target         ctrl   pc            instr         pc4           v     idex   bub red
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0000_0004, 32'h1111_0000, 32'h0000_0004, 1'b1, 8'h00, 0, 0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         8'h11, 32'h0000_0008, 32'h1111_0004, 32'h0000_0008, 1'b1, 8'h11, 0, 0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         8'h12, 32'h0000_000C, 32'h1111_0008, 32'h0000_000C, 1'b1, 8'h12, 0, 0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         8'h13, 32'h0000_0010, 32'h1111_000C, 32'h0000_0010, 1'b1, 8'h13, 0, 0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         8'hA5, 32'h0000_0010, 32'h1111_000C, 32'h0000_0010, 1'b1, 8'h00, 1, 0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         8'hA5, 32'h0000_0010, 32'h1111_000C, 32'h0000_0010, 1'b1, 8'h00, 2, 0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         8'hA5, 32'h0000_0014, 32'h1111_0010, 32'h0000_0014, 1'b1, 8'hA5, 2, 0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 32'h0000_0043, 8'h3C, 32'h0000_0040, 32'h0,         32'h0,         1'b0, 8'h3C, 2, 1);
    tbl[8]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_0080, 8'h55, 32'h0000_0040, 32'h0,         32'h0,         1'b0, 8'h00, 3, 1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 32'h0000_0080, 8'h55, 32'h0000_0080, 32'h0,         32'h0,         1'b0, 8'h55, 3, 2);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,         8'hFF, 32'h0000_0084, 32'h1111_0080, 32'h0000_0084, 1'b1, 8'h00, 4, 2);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0000_0088, 32'h1111_0084, 32'h0000_0088, 1'b1, 8'h00, 4, 2);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 32'h0000_0008, 8'h77, 32'h0000_0008, 32'h0,         32'h0,         1'b0, 8'h00, 5, 3);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].tgt, tbl[i].ctrl);
      step();
      compare_all(tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_pc4, tbl[i].e_valid,
                  tbl[i].e_idex, tbl[i].e_bub, tbl[i].e_red, $sformatf("vec%0d", i));
    end

    // Five stalls from reset: narrow counter pins at 3, wide one reaches 5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 8'hC3);
      step();
    end
    compare_all(32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 5, 0, "sat");

    // PC wrap from 0xFFFF_FFFC, target low bits masked
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 8'h01);
    step();
    compare_all(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 8'h01, 5, 1, "wrap_br");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h02);
    step();
    compare_all(32'h0, 32'h1110_FFFC, 32'h0, 1'b1, 8'h02, 5, 1, "wrap");

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0100, 8'h9A);
    step();
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all(32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 0, 0, "async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h44);
    step();
    compare_all(32'h4, 32'h1111_0000, 32'h4, 1'b1, 8'h44, 0, 0, "post_rst");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
            $urandom, (($urandom % 4) == 0) ? 8'h00 : 8'($urandom));
      step();
      compare_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
